module_alu_sequencer: RTL and testbench
=======================================

Name: module_alu_sequencer

Overview:
Execution-control stage directly upstream of the 16-bit combinational ALU (opcodes AND/OR/ADD/SUB/SHL).
- Accepts one instruction per valid/ready handshake.
- Reads operands from an internal register bank and drives registered ALU operands and control.
- Captures the ALU result and writes it back to the destination register.
- Serialised, 3-cycle multi-cycle datapath; no hazards possible.

Parameters:
W, 16, data width (matches ALU operand and result width).
NREG, 16, number of registers; r0 is hardwired to zero.
AW, $clog2(NREG), register address width (derived, not overridable).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
instr_valid_i  in  1  instruction present.
instr_ready_o  out  1  sequencer can accept.
instr_op_i  in  4  opcode: 0xD AND, 0xE OR, 0xB ADD, 0xC SUB, 0xF SHL.
instr_rd_i  in  AW  destination register.
instr_rs1_i  in  AW  source A register.
instr_rs2_i  in  AW  source B register.
instr_use_imm_i  in  1  1: operand B = instr_imm_i.
instr_imm_i  in  W  immediate.
alu_a_o  out  W  to ALU operand A.
alu_b_o  out  W  to ALU operand B.
alu_ctrl_o  out  4  to ALU control.
alu_result_i  in  W  from ALU result.
done_o  out  1  1-cycle pulse: instruction retired.
err_o  out  1  1-cycle pulse: illegal opcode retired.
dbg_addr_i  in  AW  debug read address.
dbg_data_o  out  W  combinational read of the register at dbg_addr_i (r0 reads 0).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; all registers cleared to 0.
  - alu_a_o=0, alu_b_o=0, alu_ctrl_o=0.
  - done_o=0, err_o=0, instr_ready_o=1 in the following cycle.
  - rst overrides everything, including a pending write-back; a write-back is never partially applied.
- FSM states: IDLE, EXEC, RETIRE.
  - instr_ready_o=1 only in IDLE.
  - An instruction is accepted on the edge where IDLE & valid & ready.
- Accept with legal opcode (edge ending cycle T): state->EXEC.
  - alu_a_o <= rf[rs1].
  - alu_b_o <= use_imm ? imm : rf[rs2].
  - alu_ctrl_o <= op; rd latched.
  - The r0 source reads 0.
- EXEC (cycle T+1): ALU output settles combinationally. On the closing edge: rf[rd] <= alu_result_i (dropped if rd==0); state->RETIRE.
- RETIRE (cycle T+2):
  - done_o=1; dbg_data_o already shows the new value.
  - state->IDLE; ready returns at T+3. Throughput is 1 instruction per 3 cycles.
- Accept with illegal opcode (any value not in {B,C,D,E,F}):
  - state->RETIRE directly.
  - done_o=1 and err_o=1 in cycle T+1.
  - No register write; ALU outputs hold their previous values.
- Operand and ALU output registers hold their values outside EXEC; they change only on accept.
- instr_* inputs are sampled only at accept. Changes while busy are ignored; valid held high while busy is not accepted until ready.
- Arithmetic is entirely in the ALU.
  - SUB wraps mod 2^W.
  - SHL passes full alu_b_o; shift >= W yields 0.
  - The sequencer performs no width adjustment.

Optional Feature:
Macro ALU_FLAGS_EN.
- Defined: adds outputs flag_z_o (1) and flag_n_o (1).
  - Updated on the same edge as write-back, including when rd==0.
  - Z = (alu_result_i==0); N = alu_result_i[W-1].
  - Reset to 0; unchanged on illegal opcodes.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
Package alu_seq_pkg holds:
- W default;
- the opcode localparams (OP_AND=4'hD, OP_OR=4'hE, OP_ADD=4'hB, OP_SUB=4'hC, OP_SHL=4'hF);
- an is_legal_op function;
- the state enum typedef {IDLE, EXEC, RETIRE}.

One sub-module, module_regfile:
- NREG x W registers;
- 2 combinational read ports plus 1 debug read port;
- 1 synchronous write port;
- r0 forced to 0 and writes to it ignored;
- synchronous reset clears all registers.

Test Plan:
1. Assert rst 2 cycles, release -> instr_ready_o=1, done_o=0, err_o=0, alu_*_o=0, dbg_data_o=0 for addresses 0..15.
2. ADD rd=1, rs1=0, use_imm=1, imm=0x0005 accepted at T -> T+1: alu_a_o=0, alu_b_o=5, alu_ctrl_o=0xB; T+2: done_o=1, dbg r1=0x0005; T+3: ready=1.
3. After test 2, SUB rd=2, rs1=0, rs2=1 -> r2=0xFFFB. Then SHL rd=3, rs1=1, imm=0x0012 -> r3=0x0000. Then AND/OR with imm 0x00F0 on r2 -> r4=0x00F0 (AND) and r5=0xFFFB (OR). With ALU_FLAGS_EN after the SUB: N=1, Z=0.
4. OR rd=0, rs1=1, imm=0xFFFF -> done_o pulses; dbg r0 remains 0x0000.
5. op=0x3 -> err_o=1 and done_o=1 at T+1; no register changes; ALU outputs unchanged. Hold valid high with a second instruction during busy -> it is accepted only when ready=1.
6. Accept ADD rd=6, imm=0x1234 and assert rst during EXEC -> next cycle state IDLE, ready=1, r6=0x0000, no done_o.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Desc     : Shared types, opcodes and helpers for module_alu_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int W_DEFAULT = 16;

  localparam logic [3:0] OP_AND = 4'hD;
  localparam logic [3:0] OP_OR  = 4'hE;
  localparam logic [3:0] OP_ADD = 4'hB;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_SHL = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RETIRE = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHL: is_legal_op = 1'b1;
      default:                               is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/module_alu_sequencer_regfile.sv
// ============================================================================
// Module   : module_regfile
// Desc     : NREG x W register bank, r0 hardwired to zero, 2+1 async reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module module_regfile #(
  parameter int W    = 16,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [W-1:0]  dbg_data_o
);

  logic [W-1:0] rf_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  // r0 is also masked on read so it never depends on reset having run.
  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : rf_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/module_alu_sequencer.sv
// ============================================================================
// Module   : module_alu_sequencer
// Desc     : 3-cycle execution-control stage feeding an external 16-bit ALU.
//            Optional Z/N flag outputs when ALU_FLAGS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module module_alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter  int W    = W_DEFAULT,
  parameter  int NREG = 16,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid_i,
  output logic          instr_ready_o,
  input  logic [3:0]    instr_op_i,
  input  logic [AW-1:0] instr_rd_i,
  input  logic [AW-1:0] instr_rs1_i,
  input  logic [AW-1:0] instr_rs2_i,
  input  logic          instr_use_imm_i,
  input  logic [W-1:0]  instr_imm_i,
  output logic [W-1:0]  alu_a_o,
  output logic [W-1:0]  alu_b_o,
  output logic [3:0]    alu_ctrl_o,
  input  logic [W-1:0]  alu_result_i,
  output logic          done_o,
  output logic          err_o,
  input  logic [AW-1:0] dbg_addr_i,
  output logic [W-1:0]  dbg_data_o
`ifdef ALU_FLAGS_EN
  ,
  output logic          flag_z_o,
  output logic          flag_n_o
`endif
);

  state_e        state_q, state_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          err_q, err_d;
  logic          rf_we;
  logic [W-1:0]  rdata_a, rdata_b;

  module_regfile #(
    .W    (W),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (alu_result_i),
    .raddr_a_i  (instr_rs1_i),
    .rdata_a_o  (rdata_a),
    .raddr_b_i  (instr_rs2_i),
    .rdata_b_o  (rdata_b),
    .dbg_addr_i (dbg_addr_i),
    .dbg_data_o (dbg_data_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_ctrl_q <= alu_ctrl_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    rd_d          = rd_q;
    err_d         = err_q;
    instr_ready_o = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    rf_we         = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          if (is_legal_op(instr_op_i)) begin
            state_d    = EXEC;
            alu_a_d    = rdata_a;
            alu_b_d    = instr_use_imm_i ? instr_imm_i : rdata_b;
            alu_ctrl_d = instr_op_i;
            rd_d       = instr_rd_i;
            err_d      = 1'b0;
          end else begin
            // Illegal ops skip EXEC and leave the ALU-facing registers alone.
            state_d = RETIRE;
            err_d   = 1'b1;
          end
        end
      end
      EXEC: begin
        rf_we   = 1'b1;
        state_d = RETIRE;
      end
      RETIRE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign alu_a_o    = alu_a_q;
  assign alu_b_o    = alu_b_q;
  assign alu_ctrl_o = alu_ctrl_q;

`ifdef ALU_FLAGS_EN
  logic flag_z_q, flag_n_q;

  // Flags follow every legal result, even when the write to r0 is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (rf_we) begin
      flag_z_q <= (alu_result_i == '0);
      flag_n_q <= alu_result_i[W-1];
    end
  end

  assign flag_z_o = flag_z_q;
  assign flag_n_o = flag_n_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_module_alu_sequencer.sv
// ============================================================================
// Module   : tb_module_alu_sequencer
// Desc     : Self-checking bench with a behavioural ALU and register model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_module_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [3:0]  instr_op_i;
  logic [3:0]  instr_rd_i, instr_rs1_i, instr_rs2_i;
  logic        instr_use_imm_i;
  logic [15:0] instr_imm_i;
  logic [15:0] alu_a_o, alu_b_o, alu_result_i;
  logic [3:0]  alu_ctrl_o;
  logic        done_o, err_o;
  logic [3:0]  dbg_addr_i;
  logic [15:0] dbg_data_o;
`ifdef ALU_FLAGS_EN
  logic        flag_z_o, flag_n_o;
  logic        m_z, m_n;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] mrf [16];
  logic [15:0] exp_a, exp_b;
  logic [3:0]  exp_ctrl;

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      4'hD:    return a & b;
      4'hE:    return a | b;
      4'hB:    return a + b;
      4'hC:    return a - b;
      4'hF:    return (b >= 16) ? 16'h0000 : 16'(a << b[3:0]);
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_result_i = ref_alu(alu_ctrl_o, alu_a_o, alu_b_o);

  module_alu_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid_i   (instr_valid_i),
    .instr_ready_o   (instr_ready_o),
    .instr_op_i      (instr_op_i),
    .instr_rd_i      (instr_rd_i),
    .instr_rs1_i     (instr_rs1_i),
    .instr_rs2_i     (instr_rs2_i),
    .instr_use_imm_i (instr_use_imm_i),
    .instr_imm_i     (instr_imm_i),
    .alu_a_o         (alu_a_o),
    .alu_b_o         (alu_b_o),
    .alu_ctrl_o      (alu_ctrl_o),
    .alu_result_i    (alu_result_i),
    .done_o          (done_o),
    .err_o           (err_o),
    .dbg_addr_i      (dbg_addr_i),
    .dbg_data_o      (dbg_data_o)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z_o        (flag_z_o),
    .flag_n_o        (flag_n_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic dbg_check(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    dbg_addr_i = addr;
    #1;
    check(tag, dbg_data_o, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mrf[i] = 16'h0000;
    exp_a = '0; exp_b = '0; exp_ctrl = '0;
`ifdef ALU_FLAGS_EN
    m_z = 1'b0; m_n = 1'b0;
`endif
  endtask

  function automatic logic legal(input logic [3:0] op);
    return op inside {4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic ui, input logic [15:0] imm);
    instr_valid_i = 1'b1; instr_op_i = op; instr_rd_i = rd; instr_rs1_i = rs1;
    instr_rs2_i = rs2; instr_use_imm_i = ui; instr_imm_i = imm;
  endtask

  task automatic scramble();
    instr_op_i = 4'($urandom); instr_rd_i = 4'($urandom); instr_rs1_i = 4'($urandom);
    instr_rs2_i = 4'($urandom); instr_use_imm_i = 1'($urandom); instr_imm_i = 16'($urandom);
  endtask

  // Model of one accept: returns the value that should reach rd.
  task automatic model_accept(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                              input logic ui, input logic [15:0] imm, output logic [15:0] res);
    exp_a = mrf[rs1];
    exp_b = ui ? imm : mrf[rs2];
    exp_ctrl = op;
    case (op)
      4'hD: res = exp_a & exp_b;
      4'hE: res = exp_a | exp_b;
      4'hB: res = exp_a + exp_b;
      4'hC: res = exp_a - exp_b;
      default: res = (exp_b > 16'd15) ? 16'h0 : 16'((32'(exp_a) * (32'd1 << exp_b)) & 32'hFFFF);
    endcase
  endtask

  task automatic model_write(input logic [3:0] rd, input logic [15:0] res);
    if (rd != 0) mrf[rd] = res;
`ifdef ALU_FLAGS_EN
    m_z = (res == 16'h0);
    m_n = res[15];
`endif
  endtask

  // Issue one instruction at a negedge while IDLE; returns at the next IDLE negedge.
  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic ui, input logic [15:0] imm);
    logic [15:0] res;
    check("ready_idle", instr_ready_o, 1);
    drive(op, rd, rs1, rs2, ui, imm);
    if (legal(op)) model_accept(op, rs1, rs2, ui, imm, res);
    @(negedge clk);
    instr_valid_i = 1'b0;
    scramble();
    if (legal(op)) begin
      check("exec_a", alu_a_o, exp_a);
      check("exec_b", alu_b_o, exp_b);
      check("exec_ctrl", alu_ctrl_o, exp_ctrl);
      check("exec_ready", instr_ready_o, 0);
      check("exec_done", done_o, 0);
      model_write(rd, res);
      @(negedge clk);
      check("ret_done", done_o, 1);
      check("ret_err", err_o, 0);
      dbg_check("ret_dbg", rd, mrf[rd]);
`ifdef ALU_FLAGS_EN
      check("flag_z", flag_z_o, m_z);
      check("flag_n", flag_n_o, m_n);
`endif
    end else begin
      check("ill_done", done_o, 1);
      check("ill_err", err_o, 1);
      check("ill_a", alu_a_o, exp_a);
      check("ill_b", alu_b_o, exp_b);
      check("ill_ctrl", alu_ctrl_o, exp_ctrl);
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] res;
    logic [3:0]  op;
    rst = 1'b1; instr_valid_i = 1'b0; dbg_addr_i = '0;
    scramble();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", instr_ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_a", alu_a_o, 0);
    check("rst_b", alu_b_o, 0);
    check("rst_ctrl", alu_ctrl_o, 0);
    for (int i = 0; i < 16; i++) dbg_check("rst_dbg", 4'(i), 16'h0000);
    @(negedge clk);

    issue(4'hB, 4'd1, 4'd0, 4'd0, 1'b1, 16'h0005);
    check("t2_ready", instr_ready_o, 1);
    issue(4'hC, 4'd2, 4'd0, 4'd1, 1'b0, 16'h0000);
    dbg_check("t3_sub", 4'd2, 16'hFFFB);
`ifdef ALU_FLAGS_EN
    check("t3_n", flag_n_o, 1);
    check("t3_z", flag_z_o, 0);
`endif
    issue(4'hF, 4'd3, 4'd1, 4'd0, 1'b1, 16'h0012);
    dbg_check("t3_shl", 4'd3, 16'h0000);
    issue(4'hD, 4'd4, 4'd2, 4'd0, 1'b1, 16'h00F0);
    dbg_check("t3_and", 4'd4, 16'h00F0);
    issue(4'hE, 4'd5, 4'd2, 4'd0, 1'b1, 16'h00F0);
    dbg_check("t3_or", 4'd5, 16'hFFFB);
    issue(4'hE, 4'd0, 4'd1, 4'd0, 1'b1, 16'hFFFF);
    dbg_check("t4_r0", 4'd0, 16'h0000);
    issue(4'h3, 4'd1, 4'd2, 4'd3, 1'b0, 16'h1111);
    dbg_check("t5_r1", 4'd1, 16'h0005);

    // Valid held high across a busy window: second instruction waits for ready.
    drive(4'hB, 4'd7, 4'd1, 4'd0, 1'b1, 16'h0001);
    model_accept(4'hB, 4'd1, 4'd0, 1'b1, 16'h0001, res);
    @(negedge clk);
    drive(4'hC, 4'd8, 4'd7, 4'd1, 1'b0, 16'h0000);
    check("hold_exec_ready", instr_ready_o, 0);
    model_write(4'd7, res);
    @(negedge clk);
    check("hold_ret_ready", instr_ready_o, 0);
    check("hold_ret_done", done_o, 1);
    dbg_check("hold_r7", 4'd7, 16'h0006);
    @(negedge clk);
    check("hold_idle_ready", instr_ready_o, 1);
    model_accept(4'hC, 4'd7, 4'd1, 1'b0, 16'h0000, res);
    @(negedge clk);
    instr_valid_i = 1'b0;
    check("hold2_a", alu_a_o, exp_a);
    check("hold2_b", alu_b_o, exp_b);
    check("hold2_ctrl", alu_ctrl_o, 4'hC);
    model_write(4'd8, res);
    @(negedge clk);
    check("hold2_done", done_o, 1);
    dbg_check("hold2_r8", 4'd8, 16'h0001);
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: op = 4'hB; 1: op = 4'hC; 2: op = 4'hD; 3: op = 4'hE; 4: op = 4'hF;
        default: op = 4'($urandom_range(0, 10));
      endcase
      issue(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom));
    end
    for (int i = 0; i < 16; i++) dbg_check("sweep", 4'(i), mrf[i]);

    // Reset during EXEC must drop the pending write-back.
    drive(4'hB, 4'd6, 4'd0, 4'd0, 1'b1, 16'h1234);
    @(negedge clk);
    instr_valid_i = 1'b0;
    rst = 1'b1;
    check("t6_exec_ctrl", alu_ctrl_o, 4'hB);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("t6_ready", instr_ready_o, 1);
    check("t6_done", done_o, 0);
    check("t6_a", alu_a_o, 0);
    dbg_check("t6_r6", 4'd6, 16'h0000);
    @(negedge clk);
    check("t6_done_after", done_o, 0);
    issue(4'hB, 4'd9, 4'd0, 4'd0, 1'b1, 16'h00AA);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
